// File: rtl/tod_bcd_counter.sv
// tod_bcd_counter
//   24-hour time-of-day counter (HH:MM:SS) with six BCD digit outputs. It has a
//   1 Hz prescaler and rising-edge set inputs for minutes and hours. It also
//   produces per-second, per-minute and per-day strobes for the alarm logic.
//
// Parameters
//   TICKS_PER_SEC  clk cycles per second
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   run          1 = time advances, 0 = frozen (prescaler held)
//   set_min      set-minute button level (already debounced)
//   set_hr       set-hour button level (already debounced)
//   hr_tens/hr_ones, min_tens/min_ones, sec_tens/sec_ones   BCD digits
//   sec_tick     one-cycle pulse when the prescaler reaches terminal count
//   min_strobe   one-cycle pulse when time enters a new minute (SS = 00)
//   day_wrap     one-cycle pulse on 23:59:59 -> 00:00:00
//
//   All outputs are registered.

module tod_bcd_counter #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       set_min,
    input  logic       set_hr,
    output logic [3:0] hr_tens,
    output logic [3:0] hr_ones,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       sec_tick,
    output logic       min_strobe,
    output logic       day_wrap
);

    localparam int unsigned PreW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(TICKS_PER_SEC - 1);

    // BCD two-digit increment. Returns {wrap, tens, ones}. The field wraps to
    // 00 after (last_tens, last_ones).
    function automatic logic [8:0] bcd_inc(input logic [3:0] tens,
                                           input logic [3:0] ones,
                                           input logic [3:0] last_tens,
                                           input logic [3:0] last_ones);
        logic [8:0] r;
        if (tens == last_tens && ones == last_ones) begin
            r = 9'b1_0000_0000;
        end else if (ones == 4'd9) begin
            r = {1'b0, tens + 4'd1, 4'd0};
        end else begin
            r = {1'b0, tens, ones + 4'd1};
        end
        return r;
    endfunction

    logic [PreW-1:0] pre_q, pre_d;
    logic            set_min_q, set_hr_q;
    logic            min_edge, hr_edge, tc;
    logic            sec_carry, min_carry;
    logic [8:0]      sec_inc, min_inc, hr_inc;
    logic [3:0]      ht_d, ho_d, mt_d, mo_d, st_d, so_d;
    logic            sec_tick_d, min_strobe_d, day_wrap_d;

    always_comb begin
        min_edge = set_min & ~set_min_q;
        hr_edge  = set_hr & ~set_hr_q;
        tc       = run && (pre_q == PreMax);

        sec_inc = bcd_inc(sec_tens, sec_ones, 4'd5, 4'd9);
        min_inc = bcd_inc(min_tens, min_ones, 4'd5, 4'd9);
        hr_inc  = bcd_inc(hr_tens, hr_ones, 4'd2, 4'd3);

        pre_d = pre_q;
        if (run) begin
            pre_d = tc ? '0 : pre_q + 1'b1;
        end
        if (min_edge) begin
            pre_d = '0;
        end

        ht_d      = hr_tens;
        ho_d      = hr_ones;
        mt_d      = min_tens;
        mo_d      = min_ones;
        st_d      = sec_tens;
        so_d      = sec_ones;
        sec_carry = 1'b0;
        min_carry = 1'b0;

        // A set_min edge clears SS, so the tick's own increment is dropped.
        if (tc && !min_edge) begin
            {st_d, so_d} = sec_inc[7:0];
            sec_carry    = sec_inc[8];
        end

        if (min_edge) begin
            {mt_d, mo_d} = min_inc[7:0];
            st_d         = 4'd0;
            so_d         = 4'd0;
        end else if (sec_carry) begin
            {mt_d, mo_d} = min_inc[7:0];
            min_carry    = min_inc[8];
        end

        // A set_hr edge that coincides with a minute carry still gives one +1.
        if (hr_edge || min_carry) begin
            {ht_d, ho_d} = hr_inc[7:0];
        end

        sec_tick_d   = tc;
        min_strobe_d = sec_carry || min_edge;
        day_wrap_d   = min_carry && hr_inc[8] && !hr_edge;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q      <= '0;
            set_min_q  <= 1'b0;
            set_hr_q   <= 1'b0;
            hr_tens    <= 4'd0;
            hr_ones    <= 4'd0;
            min_tens   <= 4'd0;
            min_ones   <= 4'd0;
            sec_tens   <= 4'd0;
            sec_ones   <= 4'd0;
            sec_tick   <= 1'b0;
            min_strobe <= 1'b0;
            day_wrap   <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            set_min_q  <= set_min;
            set_hr_q   <= set_hr;
            hr_tens    <= ht_d;
            hr_ones    <= ho_d;
            min_tens   <= mt_d;
            min_ones   <= mo_d;
            sec_tens   <= st_d;
            sec_ones   <= so_d;
            sec_tick   <= sec_tick_d;
            min_strobe <= min_strobe_d;
            day_wrap   <= day_wrap_d;
        end
    end

endmodule

// File: tb/tb_tod_bcd_counter.sv
// Bench for tod_bcd_counter with TICKS_PER_SEC = 4. The stimulus process
// drives each cycle's inputs and pushes that cycle's expected outputs into a
// queue. The monitor pops one entry per cycle and compares it with the DUT.

module tb_tod_bcd_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       set_min = 1'b0;
    logic       set_hr = 1'b0;
    logic [3:0] hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones;
    logic       sec_tick, min_strobe, day_wrap;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        bit          chk;
        logic [23:0] t;   // {HH, MM, SS} as BCD nibbles
        logic [2:0]  f;   // {sec_tick, min_strobe, day_wrap}
    } exp_t;

    exp_t q[$];

    tod_bcd_counter #(.TICKS_PER_SEC(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .set_min   (set_min),
        .set_hr    (set_hr),
        .hr_tens   (hr_tens),
        .hr_ones   (hr_ones),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .sec_tick  (sec_tick),
        .min_strobe(min_strobe),
        .day_wrap  (day_wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Monitor: each negedge shows the result of the preceding posedge.
    initial begin
        exp_t        e;
        logic [23:0] got_t;
        logic [2:0]  got_f;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e     = q.pop_front();
                got_t = {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones};
                got_f = {sec_tick, min_strobe, day_wrap};
                if (e.chk) begin
                    checks++;
                    if (got_t !== e.t) begin
                        errors++;
                        $display("FAIL %s time: got %h want %h", e.name, got_t, e.t);
                    end
                    checks++;
                    if (got_f !== e.f) begin
                        errors++;
                        $display("FAIL %s flags{tick,min,day}: got %b want %b",
                                 e.name, got_f, e.f);
                    end
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic ru, input logic sm, input logic sh,
                       input string nm, input logic [23:0] t, input logic [2:0] f,
                       input bit chk);
        exp_t e;
        @(negedge clk);
        #1;
        rst     = r;
        run     = ru;
        set_min = sm;
        set_hr  = sh;
        e.name  = nm;
        e.chk   = chk;
        e.t     = t;
        e.f     = f;
        q.push_back(e);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, "", '0, '0, 1'b0);
    endtask

    task automatic pulse_hr(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, "", '0, '0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, "", '0, '0, 1'b0);
        end
    endtask

    task automatic pulse_min(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, "", '0, '0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, "", '0, '0, 1'b0);
        end
    endtask

    initial begin
        int s;

        // Reset state
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "reset", 24'h000000, 3'b000, 1'b1);

        // 1: 40 clocks of run -> a tick every 4th clock, ends at 00:00:10
        for (int k = 1; k <= 40; k++) begin
            s = k / 4;
            cyc(1'b0, 1'b1, 1'b0, 1'b0, "t1_run", {16'h0000, 4'(s / 10), 4'(s % 10)},
                {(k % 4 == 0), 2'b00}, 1'b1);
        end

        // 2: preload 23:59:58, then roll over the day
        pulse_hr(23);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "t2_hr_preset", 24'h230010, 3'b000, 1'b1);
        pulse_min(59);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "t2_min_preset", 24'h235900, 3'b000, 1'b1);
        run_cycles(231);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, "t2_at_235958", 24'h235958, 3'b100, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, "t2_rollover",
                (k < 4) ? 24'h235958 : (k < 8) ? 24'h235959 : 24'h000000,
                (k == 4) ? 3'b100 : (k == 8) ? 3'b111 : 3'b000, 1'b1);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "t2_after", 24'h000000, 3'b000, 1'b1);

        // 3: MM=59 plus set_min -> MM=00, HH kept, SS=00, prescaler cleared
        pulse_hr(5);
        pulse_min(59);
        run_cycles(11);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, "t3_at_055903", 24'h055903, 3'b100, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, "t3_set_min_wrap", 24'h050000, 3'b010, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, "t3_pre_cleared",
                (k < 4) ? 24'h050000 : 24'h050001, (k == 4) ? 3'b100 : 3'b000, 1'b1);
        end

        // 4: HH=23 and set_hr held 10 clocks -> one wrap to 00, no day_wrap
        pulse_hr(18);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "t4_preset", 24'h230001, 3'b000, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, "t4_hold", 24'h000001, 3'b000, 1'b1);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "t4_release", 24'h000001, 3'b000, 1'b1);

        // 5: set_min edge together with the terminal count at SS=59
        run_cycles(231);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, "t5_ss59", 24'h000059, 3'b100, 1'b1);
        run_cycles(3);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, "t5_set_tick", 24'h000100, 3'b110, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, "t5_after",
                (k < 4) ? 24'h000100 : 24'h000101, (k == 4) ? 3'b100 : 3'b000, 1'b1);
        end
        // set_hr edge with a tick: hour +1 and seconds still advance
        run_cycles(3);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, "t5_hr_tick", 24'h010102, 3'b100, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "t5_hr_release", 24'h010102, 3'b000, 1'b1);
        // Both set edges in one cycle
        cyc(1'b0, 1'b0, 1'b1, 1'b1, "t5_both", 24'h020200, 3'b010, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "t5_both_release", 24'h020200, 3'b000, 1'b1);

        // 6: freeze mid-count for 20 clocks, prescaler must resume from 2
        run_cycles(2);
        for (int k = 1; k <= 20; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, "t6_frozen", 24'h020200, 3'b000, 1'b1);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, "t6_resume1", 24'h020200, 3'b000, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, "t6_resume2", 24'h020201, 3'b100, 1'b1);

        // Reset at 12:34:56 with a tick pending and set_min held through it
        pulse_hr(10);
        pulse_min(32);
        run_cycles(223);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, "t6_at_123456", 24'h123456, 3'b100, 1'b1);
        run_cycles(3);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, "t6_reset", 24'h000000, 3'b000, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, "t6_held_edge", 24'h000100, 3'b010, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, "t6_held_no_more", 24'h000100, 3'b000, 1'b1);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
